// File: rtl/uart_rx_if.sv
// Receive-side UART bus: serial line in, assembled byte and status strobes out.
// The master modport belongs to whoever drives the line and consumes the bytes.
// The slave modport belongs to the receiver.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;

    modport master (
        output rx,
        input  data_out,
        input  valid,
        input  busy,
        input  frame_err
    );

    modport slave (
        input  rx,
        output data_out,
        output valid,
        output busy,
        output frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, idle-high line.
// The asynchronous rx pin passes through a two-flop synchroniser.
// A start bit is qualified at its midpoint, and every later bit is sampled at mid-period.
// A good frame presents its byte with a one-cycle valid strobe.
// A frame whose stop bit reads low gives a one-cycle frame_err strobe instead.
// After a bad stop bit the receiver waits for the line to go high again, so a line held low never re-triggers.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t           state_r;
    logic [1:0]       sync_r;
    logic             rx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       shift_r;
    logic [7:0]       data_out_r;
    logic             valid_r;
    logic             busy_r;
    logic             frame_err_r;

    assign rx_s = sync_r[1];

    // Two-flop synchroniser; it resets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], bus.rx};
        end
    end

    // Receive FSM: qualifies the start bit, samples at mid-bit, and drives registered strobes and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            idx_r       <= 3'd0;
            shift_r     <= 8'h00;
            data_out_r  <= 8'h00;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (!rx_s) begin
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_r == HALF_M1) begin
                        cnt_r <= CNT_ZERO;
                        idx_r <= 3'd0;
                        if (rx_s) begin
                            // A low pulse shorter than half a bit is a glitch, not a start bit.
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r          <= CNT_ZERO;
                        shift_r[idx_r] <= rx_s;
                        if (idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r <= CNT_ZERO;
                        if (rx_s) begin
                            // Returning at mid stop bit lets the next back-to-back start edge be caught.
                            data_out_r <= shift_r;
                            valid_r    <= 1'b1;
                            state_r    <= IDLE;
                            busy_r     <= 1'b0;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= BRK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                BRK: begin
                    cnt_r <= CNT_ZERO;
                    if (rx_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_out_r;
    assign bus.valid     = valid_r;
    assign bus.busy      = busy_r;
    assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. Frames are driven at 16 clocks per bit, and each good frame pushes its byte onto a scoreboard queue.
// A negedge monitor pops the queue on every valid strobe and also counts the valid and frame_err pulses.
module tb_uart_rx;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if bus_if ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic hold_bits(input logic level, input int cycles);
        bus_if.rx = level;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        hold_bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold_bits(b[i], CPB);
        hold_bits(stop_bit, CPB);
    endtask

    // Scoreboard monitor: it compares each valid byte with the queue head and checks that the two strobes never coincide.
    always @(negedge clk) begin
        if (bus_if.valid === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {24'h0, bus_if.data_out}, 32'hFFFF_FFFF);
            end else begin
                check("data_out", {24'h0, bus_if.data_out}, {24'h0, exp_q.pop_front()});
            end
        end
        if (bus_if.frame_err === 1'b1) ferr_cnt++;
        if (bus_if.valid === 1'b1 || bus_if.frame_err === 1'b1)
            check("strobe_exclusive", {31'h0, bus_if.valid & bus_if.frame_err}, 32'h0);
    end

    initial begin
        int v0;
        int f0;
        bus_if.rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out",  {24'h0, bus_if.data_out}, 32'h00);
        check("rst_valid",     {31'h0, bus_if.valid},     32'h0);
        check("rst_busy",      {31'h0, bus_if.busy},      32'h0);
        check("rst_frame_err", {31'h0, bus_if.frame_err}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single frame 0x41
        exp_q.push_back(8'h41);
        send_byte(8'h41, 1'b1);
        hold_bits(1'b1, 2 * CPB);
        check("t1_valid_cnt", valid_cnt, 32'd1);
        check("t1_ferr_cnt",  ferr_cnt,  32'd0);
        check("t1_busy",      {31'h0, bus_if.busy}, 32'h0);
        check("t1_hold",      {24'h0, bus_if.data_out}, 32'h41);

        // 2: back-to-back 0x42, 0x55
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h55);
        send_byte(8'h42, 1'b1);
        send_byte(8'h55, 1'b1);
        hold_bits(1'b1, 2 * CPB);
        check("t2_valid_cnt", valid_cnt, 32'd3);
        check("t2_data_out",  {24'h0, bus_if.data_out}, 32'h55);

        // 3: 4-cycle glitch is rejected
        v0 = valid_cnt;
        f0 = ferr_cnt;
        hold_bits(1'b0, 4);
        hold_bits(1'b1, 8);
        check("t3_busy",      {31'h0, bus_if.busy}, 32'h0);
        hold_bits(1'b1, 2 * CPB);
        check("t3_no_valid",  valid_cnt, v0);
        check("t3_no_ferr",   ferr_cnt,  f0);

        // 4: bad stop bit, then line held low for 20 bit-times
        send_byte(8'hA5, 1'b0);
        hold_bits(1'b0, 20 * CPB);
        check("t4_ferr_cnt",  ferr_cnt,  f0 + 1);
        check("t4_no_valid",  valid_cnt, v0);
        check("t4_data_keep", {24'h0, bus_if.data_out}, 32'h55);
        check("t4_busy_brk",  {31'h0, bus_if.busy}, 32'h1);
        hold_bits(1'b1, 8);
        check("t4_busy_idle", {31'h0, bus_if.busy}, 32'h0);
        hold_bits(1'b1, 2 * CPB);

        // 5: reset in the middle of data bit 3 of 0x3C
        hold_bits(1'b0, CPB);
        hold_bits(1'b0, CPB);
        hold_bits(1'b0, CPB);
        hold_bits(1'b1, CPB);
        hold_bits(1'b1, CPB / 2);
        rst = 1'b1;
        #1;
        check("t5_rst_data",  {24'h0, bus_if.data_out}, 32'h00);
        check("t5_rst_busy",  {31'h0, bus_if.busy},      32'h0);
        check("t5_rst_valid", {31'h0, bus_if.valid},     32'h0);
        check("t5_rst_ferr",  {31'h0, bus_if.frame_err}, 32'h0);
        hold_bits(1'b1, 4);
        rst = 1'b0;
        hold_bits(1'b1, 2 * CPB);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        hold_bits(1'b1, 2 * CPB);
        check("t5_data_out",  {24'h0, bus_if.data_out}, 32'h3C);

        // 6: all-zero and all-one bytes
        exp_q.push_back(8'h00);
        send_byte(8'h00, 1'b1);
        hold_bits(1'b1, 2 * CPB);
        check("t6_data_00",   {24'h0, bus_if.data_out}, 32'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'hFF, 1'b1);
        hold_bits(1'b1, 2 * CPB);
        check("t6_data_ff",   {24'h0, bus_if.data_out}, 32'hFF);

        check("final_valid_cnt", valid_cnt, 32'd6);
        check("final_ferr_cnt",  ferr_cnt,  32'd1);
        check("final_queue",     exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
